// File: rtl/bus_timeout_pkg.sv
// Shared types and constants for the multi-channel bus timeout monitor.
package bus_timeout_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } timeout_state_e;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } timeout_mode_e;

  localparam int unsigned BUS_TIMEOUT_DEFAULT_LIMIT = 100;

endpackage

// File: rtl/timeout_channel.sv
// One watchdog channel: FSM, saturating idle counter, programmable limit and
// sticky timeout flag with acknowledge.
module timeout_channel
  import bus_timeout_pkg::*;
#(
  parameter int          WIDTH         = 16,
  parameter int unsigned DEFAULT_LIMIT = BUS_TIMEOUT_DEFAULT_LIMIT
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             i_enable,
  input  logic             i_ready,
  input  logic             i_mode,
  input  logic             i_tick,
  input  logic             i_limit_wr,
  input  logic [WIDTH-1:0] i_limit_data,
  input  logic             i_ack,
  output logic             o_thresh_pulse,
  output logic             o_timeout
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  timeout_state_e   r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_pulse;
  logic             r_timeout;

  logic [WIDTH-1:0] w_limit_m1;
  logic             w_expire;
  timeout_mode_e    w_mode;

  // A zero limit disables expiry; the >= compare also covers a limit lowered
  // below the current count.
  assign w_limit_m1 = r_limit - ONE;
  assign w_expire   = i_tick && (r_limit != '0) && (r_count >= w_limit_m1);
  assign w_mode     = timeout_mode_e'(i_mode);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_limit   <= WIDTH'(DEFAULT_LIMIT);
      r_pulse   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (i_limit_wr) r_limit <= i_limit_data;
      // NOTE: non-blocking assignments resolve last-wins, so an expiry set
      // further down overrides this ack clear in the same cycle.
      if (i_ack) r_timeout <= 1'b0;

      if (!i_enable) begin
        r_state <= IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= COUNT;
            r_count <= '0;
          end
          COUNT: begin
            if (i_ready) begin
              r_count <= '0;
            end else if (w_expire) begin
              r_pulse   <= 1'b1;
              r_timeout <= 1'b1;
              if (w_mode == PERIODIC) r_count <= '0;
              else                    r_state <= EXPIRED;
            end else if (i_tick && (r_count != CNT_MAX)) begin
              r_count <= r_count + ONE;
            end
          end
          EXPIRED: begin
            if (i_ready) begin
              r_state <= COUNT;
              r_count <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_thresh_pulse = r_pulse;
  assign o_timeout      = r_timeout;

endmodule

// File: rtl/bus_timeout_monitor.sv
// Multi-channel bus activity watchdog top: tick generation, limit-write decode
// and timeout OR. Optional shared prescaler enabled by BUS_TIMEOUT_PRESCALE_EN.
module bus_timeout_monitor
  import bus_timeout_pkg::*;
#(
  parameter int          CHANNELS      = 4,
  parameter int          WIDTH         = 16,
  parameter int unsigned DEFAULT_LIMIT = BUS_TIMEOUT_DEFAULT_LIMIT,
  parameter int          PRESCALE      = 8,
  localparam int         CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] ready,
  input  logic [CHANNELS-1:0] mode,
  input  logic                limit_wr,
  input  logic [CH_W-1:0]     limit_ch,
  input  logic [WIDTH-1:0]    limit_data,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] thresh_pulse,
  output logic [CHANNELS-1:0] timeout,
  output logic                any_timeout
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("bus_timeout_monitor: CHANNELS must be >= 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("bus_timeout_monitor: PRESCALE must be >= 1");
  end

  logic w_tick;

`ifdef BUS_TIMEOUT_PRESCALE_EN
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_prescale;
  logic            w_any_enable;

  assign w_any_enable = |enable;

  // Free-running phase shared by all channels; ready does not realign it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_prescale <= '0;
    end else if (w_any_enable) begin
      r_prescale <= (r_prescale == PS_LAST) ? '0 : r_prescale + PS_W'(1);
    end
  end

  assign w_tick = w_any_enable && (r_prescale == PS_LAST);
`else
  assign w_tick = 1'b1;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic w_wr;

    // Out-of-range channel indices match no channel and are dropped.
    assign w_wr = limit_wr && (limit_ch == CH_W'(g));

    timeout_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_LIMIT(DEFAULT_LIMIT)
    ) u_ch (
      .clk           (clk),
      .rstN          (rstN),
      .i_enable      (enable[g]),
      .i_ready       (ready[g]),
      .i_mode        (mode[g]),
      .i_tick        (w_tick),
      .i_limit_wr    (w_wr),
      .i_limit_data  (limit_data),
      .i_ack         (ack[g]),
      .o_thresh_pulse(thresh_pulse[g]),
      .o_timeout     (timeout[g])
    );
  end

  assign any_timeout = |timeout;

endmodule
